// File: rtl/hex_display_pkg.sv
// Shared definitions for the multiplexed seven-segment display scanner.
// Holds the scan FSM state type, the digit count (four result bits plus
// carry) and the default "all segments off" pattern for active-low displays.
package hex_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam int NUM_DIGITS  = 5;
  localparam int CARRY_DIGIT = 4;

  localparam logic [7:0] DEFAULT_SEG_OFF = 8'hFF;

endpackage

// File: rtl/scan_slot_timer.sv
// Loadable down-counter timing one BLANK or SHOW slot of the scanner.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (count -> 0)
//   load     in   load load_val this cycle (takes priority over counting)
//   load_val in   slot length minus one
//   tc       out  terminal count: the current cycle is the last of the slot
module scan_slot_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counts down and parks at zero; a slot of length L is loaded as L-1.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexes five 8-bit seven-segment patterns (result bits 0..3 and
// carry) onto one shared segment bus with active-low per-digit enables.
// New pattern sets enter a shadow bank through a valid/ready handshake and
// are copied to the active bank only at a frame boundary, so one frame never
// mixes old and new patterns.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   en                 scan enable; low forces IDLE with blank outputs
//   load_valid/ready   handshake for seg_in0..seg_in4 (ready = nothing pending)
//   seg_in0..seg_in4   patterns for digits 0..3 and the carry digit
//   seg_out            shared segment bus (registered)
//   dig_out            active-low digit enables (registered)
//   frame_done         one-cycle pulse on the first cycle of a frame after a commit
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int         CLK_DIV      = 4,
  parameter int         BLANK_CYCLES = 1,
  parameter logic [7:0] SEG_OFF      = DEFAULT_SEG_OFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] seg_in0,
  input  logic [7:0] seg_in1,
  input  logic [7:0] seg_in2,
  input  logic [7:0] seg_in3,
  input  logic [7:0] seg_in4,
  output logic [7:0] seg_out,
  output logic [4:0] dig_out,
  output logic       frame_done
);

  localparam int MAX_CNT = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CNT < 2) ? 1 : $clog2(MAX_CNT);
  localparam logic [CNT_W-1:0] SHOW_LD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = (BLANK_CYCLES > 0) ? CNT_W'(BLANK_CYCLES - 1) : '0;

  scan_state_t state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        pending_q, pending_d;
  logic [7:0]  shadow_q [NUM_DIGITS];
  logic [7:0]  shadow_d [NUM_DIGITS];
  logic [7:0]  active_q [NUM_DIGITS];
  logic [7:0]  active_d [NUM_DIGITS];
  logic [7:0]  seg_out_q, seg_out_d;
  logic [4:0]  dig_out_q, dig_out_d;
  logic        frame_done_q, frame_done_d;

  logic                 tmr_load;
  logic [CNT_W-1:0]     tmr_val;
  logic                 tmr_tc;
  logic                 commit;
  logic                 accept;

  scan_slot_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Scan sequencing: each digit slot is BLANK then SHOW; with no blank
  // cycles configured the FSM goes straight from SHOW to the next SHOW.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    commit   = 1'b0;
    if (!en) begin
      state_d  = IDLE;
      idx_d    = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          idx_d    = '0;
          tmr_load = 1'b1;
          if (BLANK_CYCLES > 0) begin
            state_d = BLANK;
            tmr_val = BLANK_LD;
          end else begin
            state_d = SHOW;
            tmr_val = SHOW_LD;
          end
        end
        BLANK: begin
          if (tmr_tc) begin
            state_d  = SHOW;
            tmr_load = 1'b1;
            tmr_val  = SHOW_LD;
          end
        end
        SHOW: begin
          if (tmr_tc) begin
            // Last cycle of the carry digit is the frame boundary.
            if (idx_q == 3'(CARRY_DIGIT)) begin
              idx_d  = '0;
              commit = pending_q;
            end else begin
              idx_d = idx_q + 3'd1;
            end
            tmr_load = 1'b1;
            if (BLANK_CYCLES > 0) begin
              state_d = BLANK;
              tmr_val = BLANK_LD;
            end else begin
              state_d = SHOW;
              tmr_val = SHOW_LD;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shadow/active banks. A commit needs pending=1 and an accept needs
  // pending=0, so the two never coincide.
  always_comb begin
    accept    = load_valid && !pending_q;
    pending_d = pending_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    if (commit) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d[0] = seg_in0;
      shadow_d[1] = seg_in1;
      shadow_d[2] = seg_in2;
      shadow_d[3] = seg_in3;
      shadow_d[4] = seg_in4;
      pending_d   = 1'b1;
    end
  end

  // Outputs are decoded from next-state values so the registered outputs
  // line up with the state register.
  always_comb begin
    seg_out_d    = SEG_OFF;
    dig_out_d    = 5'b11111;
    frame_done_d = commit;
    if (state_d == SHOW && idx_d <= 3'(CARRY_DIGIT)) begin
      seg_out_d = active_d[idx_d];
      dig_out_d = 5'b11111 ^ (5'b00001 << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      seg_out_q    <= SEG_OFF;
      dig_out_q    <= 5'b11111;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= SEG_OFF;
        active_q[i] <= SEG_OFF;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      seg_out_q    <= seg_out_d;
      dig_out_q    <= dig_out_d;
      frame_done_q <= frame_done_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
    end
  end

  assign load_ready = !pending_q;
  assign seg_out    = seg_out_q;
  assign dig_out    = dig_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
module tb_hex_display_scanner;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: CLK_DIV=4, BLANK_CYCLES=1
  logic       a_rst, a_en, a_lv, a_rdy, a_fd;
  logic [7:0] a_seg [5];
  logic [7:0] a_sout;
  logic [4:0] a_dout;

  // Instance B: CLK_DIV=1, BLANK_CYCLES=0
  logic       b_rst, b_en, b_lv, b_rdy, b_fd;
  logic [7:0] b_seg [5];
  logic [7:0] b_sout;
  logic [4:0] b_dout;

  hex_display_scanner #(.CLK_DIV(4), .BLANK_CYCLES(1), .SEG_OFF(8'hFF)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .load_valid(a_lv), .load_ready(a_rdy),
    .seg_in0(a_seg[0]), .seg_in1(a_seg[1]), .seg_in2(a_seg[2]),
    .seg_in3(a_seg[3]), .seg_in4(a_seg[4]),
    .seg_out(a_sout), .dig_out(a_dout), .frame_done(a_fd)
  );

  hex_display_scanner #(.CLK_DIV(1), .BLANK_CYCLES(0), .SEG_OFF(8'hFF)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .load_valid(b_lv), .load_ready(b_rdy),
    .seg_in0(b_seg[0]), .seg_in1(b_seg[1]), .seg_in2(b_seg[2]),
    .seg_in3(b_seg[3]), .seg_in4(b_seg[4]),
    .seg_out(b_sout), .dig_out(b_dout), .frame_done(b_fd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pattern sets: 0 = 8'hC0 on every digit, 1 = A0..A4, 2 = 50..54
  function automatic logic [7:0] pat(input int ds, input int k);
    case (ds)
      1:       pat = 8'hA0 + 8'(k);
      2:       pat = 8'h50 + 8'(k);
      default: pat = 8'hC0;
    endcase
  endfunction

  typedef struct {
    int         n;
    bit         chk;
    bit         rst;
    bit         en;
    bit         lv;
    int         ds;
    logic [7:0] seg;
    logic [4:0] dig;
    bit         rdy;
    bit         fd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input bit chk, input bit rst, input bit en, input bit lv,
                     input int ds, input logic [7:0] seg, input logic [4:0] dig,
                     input bit rdy, input bit fd);
    vec_t v;
    v.n = n; v.chk = chk; v.rst = rst; v.en = en; v.lv = lv; v.ds = ds;
    v.seg = seg; v.dig = dig; v.rdy = rdy; v.fd = fd;
    vecs.push_back(v);
  endtask

  task automatic check_b(input string nm, input logic [7:0] seg, input logic [4:0] dig,
                         input bit rdy, input bit fd);
    check({nm, ".seg"}, 32'(b_sout), 32'(seg));
    check({nm, ".dig"}, 32'(b_dout), 32'(dig));
    check({nm, ".rdy"}, 32'(b_rdy), 32'(rdy));
    check({nm, ".fd"},  32'(b_fd),  32'(fd));
  endtask

  initial begin
    a_rst = 1'b1; a_en = 1'b0; a_lv = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_lv = 1'b0;
    for (int k = 0; k < 5; k++) begin
      a_seg[k] = 8'h00;
      b_seg[k] = 8'h00;
    end

    //  n  chk rst en lv ds seg    dig       rdy fd
    add(2,  1, 1, 0, 0, 0, 8'hFF, 5'b11111, 1, 0);  // reset state
    // first frame after enable, active still at reset value
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);
    add(4,  1, 0, 1, 0, 0, 8'hFF, 5'b11110, 1, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);
    add(4,  1, 0, 1, 0, 0, 8'hFF, 5'b11101, 1, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);
    add(4,  1, 0, 1, 0, 0, 8'hFF, 5'b11011, 1, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);
    add(4,  1, 0, 1, 0, 0, 8'hFF, 5'b10111, 1, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);
    add(4,  1, 0, 1, 0, 0, 8'hFF, 5'b01111, 1, 0);
    // frame 2: mid-frame load of C0
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11110, 1, 0);
    add(1,  1, 0, 1, 1, 0, 8'hFF, 5'b11110, 0, 0);
    add(2,  1, 0, 1, 0, 0, 8'hFF, 5'b11110, 0, 0);
    add(19, 0, 0, 1, 0, 0, 8'hFF, 5'b11111, 0, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b01111, 0, 0);
    // frame 3: C0 committed
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 1);
    add(4,  1, 0, 1, 0, 0, 8'hC0, 5'b11110, 1, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);
    add(4,  1, 0, 1, 0, 0, 8'hC0, 5'b11101, 1, 0);
    add(15, 0, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);
    // load A0..A4 in the boundary cycle: captured, not committed here
    add(1,  1, 0, 1, 1, 1, 8'hFF, 5'b11111, 0, 0);
    // second load 50..54 held while pending
    add(1,  1, 0, 1, 1, 2, 8'hC0, 5'b11110, 0, 0);
    add(3,  1, 0, 1, 1, 2, 8'hC0, 5'b11110, 0, 0);
    add(19, 0, 0, 1, 1, 2, 8'hFF, 5'b11111, 0, 0);
    add(1,  1, 0, 1, 1, 2, 8'hC0, 5'b01111, 0, 0);
    add(1,  1, 0, 1, 1, 2, 8'hFF, 5'b11111, 1, 1);  // commit A*
    add(1,  1, 0, 1, 1, 2, 8'hA0, 5'b11110, 0, 0);  // 50.. accepted now
    add(3,  1, 0, 1, 0, 0, 8'hA0, 5'b11110, 0, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 0, 0);
    add(4,  1, 0, 1, 0, 0, 8'hA1, 5'b11101, 0, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 0, 0);
    add(4,  1, 0, 1, 0, 0, 8'hA2, 5'b11011, 0, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 0, 0);
    add(4,  1, 0, 1, 0, 0, 8'hA3, 5'b10111, 0, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 0, 0);
    add(4,  1, 0, 1, 0, 0, 8'hA4, 5'b01111, 0, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 1);  // commit 5*
    add(4,  1, 0, 1, 0, 0, 8'h50, 5'b11110, 1, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);
    add(4,  1, 0, 1, 0, 0, 8'h51, 5'b11101, 1, 0);
    // pending load of A*, then en drops during digit 2 SHOW
    add(1,  1, 0, 1, 1, 1, 8'hFF, 5'b11111, 0, 0);
    add(2,  1, 0, 1, 0, 0, 8'h52, 5'b11011, 0, 0);
    add(3,  1, 0, 0, 0, 0, 8'hFF, 5'b11111, 0, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 0, 0);  // restart at digit 0 BLANK
    add(4,  1, 0, 1, 0, 0, 8'h50, 5'b11110, 0, 0);
    add(20, 0, 0, 1, 0, 0, 8'hFF, 5'b11111, 0, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 1);
    add(4,  1, 0, 1, 0, 0, 8'hA0, 5'b11110, 1, 0);
    // pending load of 5*, then reset mid-frame
    add(1,  1, 0, 1, 1, 2, 8'hFF, 5'b11111, 0, 0);
    add(2,  1, 0, 1, 0, 0, 8'hA1, 5'b11101, 0, 0);
    add(1,  1, 1, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);
    add(4,  1, 0, 1, 0, 0, 8'hFF, 5'b11110, 1, 0);
    add(20, 0, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);
    add(1,  1, 0, 1, 0, 0, 8'hFF, 5'b11111, 1, 0);  // no commit after reset
    add(4,  1, 0, 1, 0, 0, 8'hFF, 5'b11110, 1, 0);

    for (int r = 0; r < vecs.size(); r++) begin
      for (int i = 0; i < vecs[r].n; i++) begin
        a_rst = vecs[r].rst;
        a_en  = vecs[r].en;
        a_lv  = vecs[r].lv;
        for (int k = 0; k < 5; k++) a_seg[k] = pat(vecs[r].ds, k);
        step();
        if (vecs[r].chk) begin
          check($sformatf("v%0d.%0d.seg", r, i), 32'(a_sout), 32'(vecs[r].seg));
          check($sformatf("v%0d.%0d.dig", r, i), 32'(a_dout), 32'(vecs[r].dig));
          check($sformatf("v%0d.%0d.rdy", r, i), 32'(a_rdy),  32'(vecs[r].rdy));
          check($sformatf("v%0d.%0d.fd",  r, i), 32'(a_fd),   32'(vecs[r].fd));
        end
      end
    end

    // Instance B: one cycle per digit, no blanking, 5-cycle frame
    b_rst = 1'b1; b_en = 1'b0;
    step();
    check_b("b_reset", 8'hFF, 5'b11111, 1, 0);
    b_rst = 1'b0; b_en = 1'b1;
    step();
    check_b("b_d0", 8'hFF, 5'b11110, 1, 0);
    b_lv = 1'b1;
    for (int k = 0; k < 5; k++) b_seg[k] = pat(1, k);
    step();
    b_lv = 1'b0;
    check_b("b_d1", 8'hFF, 5'b11101, 0, 0);
    for (int k = 2; k < 5; k++) begin
      step();
      check_b($sformatf("b_d%0d", k), 8'hFF, 5'b11111 ^ (5'b00001 << k), 0, 0);
    end
    step();
    check_b("b_commit", 8'hA0, 5'b11110, 1, 1);
    step();
    check_b("b_f2d1", 8'hA1, 5'b11101, 1, 0);
    b_lv = 1'b1;
    for (int k = 0; k < 5; k++) b_seg[k] = pat(2, k);
    step();
    b_lv = 1'b0;
    check_b("b_f2d2", 8'hA2, 5'b11011, 0, 0);
    b_rst = 1'b1;
    step();
    check_b("b_rst", 8'hFF, 5'b11111, 1, 0);
    b_rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_b($sformatf("b_post%0d", k), 8'hFF, 5'b11111 ^ (5'b00001 << k), 1, 0);
    end
    step();
    check_b("b_nocommit", 8'hFF, 5'b11110, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
